// File: rtl/universal_regi.sv
// universal_regi: falling-edge universal register with hold, load, shift,
// rotate, increment and decrement. Also reports the carry, borrow or
// shifted-out bit, and flags an all-zero value combinationally.
module universal_regi #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             sel,
   input  logic [2:0]       mode,
   input  logic             sin,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             zero
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROTL = 3'b100;
   localparam logic [2:0] M_ROTR = 3'b101;
   localparam logic [2:0] M_INC  = 3'b110;
   localparam logic [2:0] M_DEC  = 3'b111;

   localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d;
   logic [WIDTH:0]   inc_ext, dec_ext;

   // The adder and subtractor are one bit wider than the data path. The extra
   // top bit is the wrap flag: inc carries out from all ones, and dec borrows
   // from zero.
   assign inc_ext = {1'b0, out_q} + ONE_EXT;
   assign dec_ext = {1'b0, out_q} - ONE_EXT;

   // Next-state selection; sel=0 keeps both out and cout untouched.
   always_comb begin
      out_d  = out_q;
      cout_d = cout_q;
      if (sel) begin
         case (mode)
            M_HOLD: cout_d = 1'b0;
            M_LOAD: begin
               out_d  = in;
               cout_d = 1'b0;
            end
            M_SHL: begin
               out_d  = {out_q[WIDTH-2:0], sin};
               cout_d = out_q[WIDTH-1];
            end
            M_SHR: begin
               out_d  = {sin, out_q[WIDTH-1:1]};
               cout_d = out_q[0];
            end
            M_ROTL: begin
               out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
               cout_d = 1'b0;
            end
            M_ROTR: begin
               out_d  = {out_q[0], out_q[WIDTH-1:1]};
               cout_d = 1'b0;
            end
            M_INC: begin
               out_d  = inc_ext[WIDTH-1:0];
               cout_d = inc_ext[WIDTH];
            end
            M_DEC: begin
               out_d  = dec_ext[WIDTH-1:0];
               cout_d = dec_ext[WIDTH];
            end
            default: begin
               out_d  = out_q;
               cout_d = cout_q;
            end
         endcase
      end
   end

   // State update on the falling edge; synchronous reset overrides any operation.
   always_ff @(negedge clk) begin
      if (rst) begin
         out_q  <= RST_VAL;
         cout_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         cout_q <= cout_d;
      end
   end

   assign out  = out_q;
   assign cout = cout_q;
   assign zero = (out_q == '0);

endmodule

// File: tb/tb_universal_regi.sv
// Testbench for universal_regi. It runs a table of directed vectors, then
// random operations checked against a reference model, then directed
// sequences for reset and for input changes between edges.
module tb_universal_regi;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] din = 8'h00;
   logic       sin = 1'b0;
   logic [7:0] out, out2;
   logic       cout, cout2, zero, zero2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   universal_regi #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .in(din), .sel(sel), .mode(mode), .sin(sin),
      .out(out), .cout(cout), .zero(zero));

   universal_regi #(.WIDTH(8), .RST_VAL(8'h3C)) dut2 (
      .clk(clk), .rst(rst), .in(din), .sel(sel), .mode(mode), .sin(sin),
      .out(out2), .cout(cout2), .zero(zero2));

   typedef struct {
      logic       rst;
      logic       sel;
      logic [2:0] mode;
      logic [7:0] din;
      logic       sin;
      logic [7:0] eout;
      logic       ecout;
      logic       ezero;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change on the rising edge. Outputs are sampled 1ns after the falling edge.
   task automatic step(input logic r, input logic s, input logic [2:0] m,
                       input logic [7:0] d, input logic si);
      @(posedge clk);
      rst = r; sel = s; mode = m; din = d; sin = si;
      @(negedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic r, logic s, logic [2:0] m, logic [7:0] d,
                               logic si, logic [7:0] eo, logic ec, logic ez);
      vec_t v;
      v.rst = r; v.sel = s; v.mode = m; v.din = d; v.sin = si;
      v.eout = eo; v.ecout = ec; v.ezero = ez;
      return v;
   endfunction

   // Reference model state, updated with plain integer arithmetic.
   int m_out, m_cout;

   task automatic model(input int r, input int s, input int m, input int d, input int si);
      int o;
      o = m_out;
      if (r != 0) begin
         m_out = 0; m_cout = 0;
      end else if (s != 0) begin
         case (m)
            0: m_cout = 0;
            1: begin m_out = d; m_cout = 0; end
            2: begin m_cout = o / 128; m_out = (o * 2 + si) % 256; end
            3: begin m_cout = o % 2; m_out = o / 2 + si * 128; end
            4: begin m_cout = 0; m_out = (o * 2) % 256 + o / 128; end
            5: begin m_cout = 0; m_out = o / 2 + (o % 2) * 128; end
            6: begin m_cout = (o == 255) ? 1 : 0; m_out = (o + 1) % 256; end
            default: begin m_cout = (o == 0) ? 1 : 0; m_out = (o + 255) % 256; end
         endcase
      end
   endtask

   initial begin
      vecs[0]  = mk(1, 1, 3'd1, 8'hFF, 0, 8'h00, 0, 1);
      vecs[1]  = mk(0, 1, 3'd1, 8'hA5, 0, 8'hA5, 0, 0);
      vecs[2]  = mk(0, 0, 3'd6, 8'h00, 1, 8'hA5, 0, 0);
      vecs[3]  = mk(0, 0, 3'd6, 8'h11, 0, 8'hA5, 0, 0);
      vecs[4]  = mk(0, 0, 3'd6, 8'h22, 1, 8'hA5, 0, 0);
      vecs[5]  = mk(0, 1, 3'd1, 8'h81, 0, 8'h81, 0, 0);
      vecs[6]  = mk(0, 1, 3'd2, 8'h00, 0, 8'h02, 1, 0);
      vecs[7]  = mk(0, 1, 3'd3, 8'h00, 1, 8'h81, 0, 0);
      vecs[8]  = mk(0, 1, 3'd1, 8'h81, 0, 8'h81, 0, 0);
      vecs[9]  = mk(0, 1, 3'd4, 8'h00, 0, 8'h03, 0, 0);
      vecs[10] = mk(0, 1, 3'd5, 8'h00, 0, 8'h81, 0, 0);
      vecs[11] = mk(0, 1, 3'd5, 8'h00, 0, 8'hC0, 0, 0);
      vecs[12] = mk(0, 1, 3'd1, 8'hFE, 0, 8'hFE, 0, 0);
      vecs[13] = mk(0, 1, 3'd6, 8'h00, 0, 8'hFF, 0, 0);
      vecs[14] = mk(0, 1, 3'd6, 8'h00, 0, 8'h00, 1, 1);
      vecs[15] = mk(0, 1, 3'd7, 8'h00, 0, 8'hFF, 1, 0);
      vecs[16] = mk(0, 0, 3'd7, 8'h55, 1, 8'hFF, 1, 0);
      vecs[17] = mk(0, 1, 3'd0, 8'h55, 1, 8'hFF, 0, 0);

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].rst, vecs[i].sel, vecs[i].mode, vecs[i].din, vecs[i].sin);
         chk($sformatf("vec%0d out", i), 64'(out), 64'(vecs[i].eout));
         chk($sformatf("vec%0d cout", i), 64'(cout), 64'(vecs[i].ecout));
         chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].ezero));
      end

      // Random operations checked against the model.
      m_out = 8'hFF; m_cout = 0;
      for (int i = 0; i < 400; i++) begin
         int r, s, m, d, si;
         r  = ($urandom_range(0, 15) == 0) ? 1 : 0;
         s  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         m  = $urandom_range(0, 7);
         d  = $urandom_range(0, 255);
         si = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) d = (($urandom_range(0, 1) == 0) ? 0 : 255);
         step(r[0], s[0], m[2:0], d[7:0], si[0]);
         model(r, s, m, d, si);
         chk($sformatf("rnd%0d m%0d out", i, m), 64'(out), 64'(m_out));
         chk($sformatf("rnd%0d m%0d cout", i, m), 64'(cout), 64'(m_cout));
         chk($sformatf("rnd%0d zero", i), 64'(zero), 64'((m_out == 0) ? 1 : 0));
      end

      // Reset in the middle of an inc run; dut2 resets to 8'h3C.
      step(1, 0, 3'd0, 8'h00, 0);
      chk("rstv out2", 64'(out2), 64'h3C);
      step(0, 1, 3'd6, 8'h00, 0);
      step(0, 1, 3'd6, 8'h00, 0);
      chk("inc2 out2", 64'(out2), 64'h3E);
      chk("inc2 out", 64'(out), 64'h02);
      step(1, 1, 3'd6, 8'h00, 0);
      chk("midrst out2", 64'(out2), 64'h3C);
      chk("midrst cout2", 64'(cout2), 64'h0);
      chk("midrst out", 64'(out), 64'h00);
      chk("midrst zero", 64'(zero), 64'h1);
      chk("midrst zero2", 64'(zero2), 64'h0);
      step(0, 1, 3'd6, 8'h00, 0);
      chk("postrst out2", 64'(out2), 64'h3D);
      chk("postrst out", 64'(out), 64'h01);

      // Inputs that change and change back between edges have no effect.
      step(0, 1, 3'd1, 8'h5A, 0);
      chk("ld5A out", 64'(out), 64'h5A);
      @(posedge clk);
      sel = 1'b1; mode = 3'd1; din = 8'hFF; rst = 1'b0;
      #1;
      chk("midcyc out", 64'(out), 64'h5A);
      mode = 3'd6; sin = 1'b1;
      #1;
      chk("midcyc2 out", 64'(out), 64'h5A);
      sel = 1'b0;
      @(negedge clk);
      #1;
      chk("midcyc hold", 64'(out), 64'h5A);
      chk("midcyc cout", 64'(cout), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/universal_regi.md
UNIVERSAL_REGI -- requirements
Module: universal_regi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RST_VAL, default 0, a WIDTH-bit value loaded into out on reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the falling edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset, sampled on the falling edge of clk.
REQ-005 The block SHALL have port in, input, WIDTH bits, the parallel load data.
REQ-006 The block SHALL have port sel, input, 1 bit, the operation enable; 0 forces hold.
REQ-007 The block SHALL have port mode, input, 3 bits, the operation select when sel=1.
REQ-008 The block SHALL have port sin, input, 1 bit, the serial input bit for shift modes.
REQ-009 The block SHALL have port out, output reg, WIDTH bits, the register contents.
REQ-010 The block SHALL have port cout, output reg, 1 bit, the registered carry/borrow/shifted-out bit of the last operation.
REQ-011 The block SHALL have port zero, output, 1 bit, combinational (out == 0).

Function
REQ-012 mode encoding SHALL be:
- 000 hold
- 001 load in
- 010 shl: out <= {out[WIDTH-2:0], sin}
- 011 shr: out <= {sin, out[WIDTH-1:1]}
- 100 rotl
- 101 rotr
- 110 inc
- 111 dec
REQ-013 Each operation SHALL complete in one falling edge; the new out is visible immediately after that edge (latency 1).
REQ-014 With sel=0, out and cout SHALL hold their previous values regardless of mode, in and sin.
REQ-015 With sel=1 and mode=000, out SHALL hold and cout SHALL clear to 0.
REQ-016 On load, cout SHALL clear to 0.
REQ-017 On rotl and rotr, cout SHALL clear to 0.
REQ-018 On shl, cout SHALL capture the old out[WIDTH-1].
REQ-019 On shr, cout SHALL capture the old out[0].
REQ-020 On rotl, the old out[WIDTH-1] SHALL enter bit 0.
REQ-021 On rotr, the old out[0] SHALL enter bit WIDTH-1.
REQ-022 inc SHALL compute out+1 modulo 2^WIDTH; cout=1 only when the old out is all ones (wrap to 0), else 0.
REQ-023 dec SHALL compute out-1 modulo 2^WIDTH; cout=1 only when the old out is 0 (wrap to all ones), else 0.
REQ-024 zero SHALL track out combinationally, with no extra register stage.
REQ-025 Inputs (in, sel, mode, sin) SHALL be sampled only on the falling edge; changes between edges SHALL have no effect.

Reset
REQ-026 When rst=1 at a falling edge, out SHALL load RST_VAL and cout SHALL load 0, overriding sel and mode.
REQ-027 Reset asserted mid-sequence (for example during a run of inc) SHALL abort the sequence; the next operation after rst deasserts SHALL start from RST_VAL.
REQ-028 Before the first reset, out and cout SHALL be unspecified; the bench SHALL apply reset first.

Verification (WIDTH=8, RST_VAL=0 unless stated)
REQ-029 rst=1 for one edge with sel=1, mode=001, in=8'hFF -> out=8'h00, cout=0, zero=1.
REQ-030 load 8'hA5, then sel=0 with mode=110 for 3 edges -> out stays 8'hA5, cout=0.
REQ-031 load 8'h81, shl sin=0 -> out=8'h02, cout=1; then shr sin=1 -> out=8'h81, cout=0.
REQ-032 load 8'h81, rotl -> out=8'h03, cout=0; then rotr twice -> out=8'hC0.
REQ-033 load 8'hFE, inc, inc -> out=8'hFF with cout=0, then out=8'h00 with cout=1 and zero=1; then dec -> out=8'hFF, cout=1.
REQ-034 RST_VAL=8'h3C: inc for 2 edges, assert rst on the 3rd edge with mode=110 -> out=8'h3C, cout=0; the next inc gives 8'h3D.
